// File: rtl/sdram_arb_pkg.sv
// Shared widths and types for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;

    typedef logic port_id_t;

    // be is stored already inverted, exactly as it goes to the controller
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              is_write;
        port_id_t          id;
    } cmd_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Port-ID FIFO recording which requester owns each outstanding read.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  port_id_t                     push_id,
    input  logic                         pop,
    output port_id_t                     head_id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    port_id_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    assign head_id = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller: port 0 has
// priority with bounded starvation of port 1, reads return in order by tag.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_PEND     = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [DATA_W-1:0] p0_writedata,
    input  logic [BE_W-1:0]   p0_byteenable,
    output logic              p0_waitrequest,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_readdatavalid,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [DATA_W-1:0] p1_writedata,
    input  logic [BE_W-1:0]   p1_byteenable,
    output logic              p1_waitrequest,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic [BE_W-1:0]   m_byteenable_n,
    output logic              m_chipselect,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read_n,
    output logic              m_write_n,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest,
    output logic              err_orphan
);

    localparam int   CNT_W = $clog2(MAX_PEND + 1);
    localparam int   SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam cmd_t CMD_RESET = '{addr: '0, wdata: '0, be: '1, is_write: 1'b0, id: 1'b0};

    cmd_t              cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              p0_rdv_q, p0_rdv_d, p1_rdv_q, p1_rdv_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_orphan_q, err_orphan_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    port_id_t          head_id;
    logic              load, held_read, read_ok, p0_elig, p1_elig;
    logic              grant0, grant1, tag_push, tag_pop;
    logic [CNT_W:0]    pend_total;

    always_comb begin
        load      = !cmd_valid_q || !m_waitrequest;
        held_read = cmd_valid_q && !cmd_q.is_write;
        // a read still sitting in the slot will need a tag once accepted
        pend_total = {1'b0, fifo_count} + (CNT_W+1)'(held_read);
        read_ok    = pend_total < (CNT_W+1)'(MAX_PEND);
        p0_elig    = p0_write || (p0_read && read_ok);
        p1_elig    = p1_write || (p1_read && read_ok);
        grant1     = load && p1_elig && (!p0_elig || starve_q == SC_W'(STARVE_LIMIT));
        grant0     = load && p0_elig && !grant1;

        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        if (load) begin
            cmd_valid_d = grant0 || grant1;
        end
        if (grant0 || grant1) begin
            cmd_d.id       = grant1;
            cmd_d.is_write = grant1 ? p1_write : p0_write;
            cmd_d.addr     = grant1 ? p1_address : p0_address;
            cmd_d.wdata    = grant1 ? p1_writedata : p0_writedata;
            cmd_d.be       = cmd_d.is_write ? ~(grant1 ? p1_byteenable : p0_byteenable) : '0;
        end

        starve_d = starve_q;
        if (!(p1_read || p1_write) || grant1) begin
            starve_d = '0;
        end else if (grant0 && p1_elig && starve_q != SC_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + SC_W'(1);
        end

        tag_push     = cmd_valid_q && !cmd_q.is_write && !m_waitrequest;
        tag_pop      = m_readdatavalid && !fifo_empty;
        p0_rdv_d     = tag_pop && (head_id == 1'b0);
        p1_rdv_d     = tag_pop && (head_id == 1'b1);
        err_orphan_d = err_orphan_q || (m_readdatavalid && fifo_empty);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_q        <= CMD_RESET;
            cmd_valid_q  <= 1'b0;
            starve_q     <= '0;
            p0_rdv_q     <= 1'b0;
            p1_rdv_q     <= 1'b0;
            rdata_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            starve_q     <= starve_d;
            p0_rdv_q     <= p0_rdv_d;
            p1_rdv_q     <= p1_rdv_d;
            rdata_q      <= m_readdata;
            err_orphan_q <= err_orphan_d;
        end
    end

    sdram_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (tag_push),
        .push_id (cmd_q.id),
        .pop     (tag_pop),
        .head_id (head_id),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // the slot is empty during reset, so grants must be masked explicitly
    assign p0_waitrequest   = !(reset_reset_n && grant0);
    assign p1_waitrequest   = !(reset_reset_n && grant1);
    assign p0_readdatavalid = p0_rdv_q;
    assign p1_readdatavalid = p1_rdv_q;
    assign p0_readdata      = rdata_q;
    assign p1_readdata      = rdata_q;
    assign m_chipselect     = cmd_valid_q;
    assign m_read_n         = !held_read;
    assign m_write_n        = !(cmd_valid_q && cmd_q.is_write);
    assign m_address        = cmd_q.addr;
    assign m_writedata      = cmd_q.wdata;
    assign m_byteenable_n   = cmd_q.be;
    assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a simple in-order controller model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic [ADDR_W-1:0] p0_address, p1_address;
    logic              p0_read, p0_write, p1_read, p1_write;
    logic [DATA_W-1:0] p0_writedata, p1_writedata;
    logic [BE_W-1:0]   p0_byteenable, p1_byteenable;
    logic              p0_waitrequest, p1_waitrequest;
    logic [DATA_W-1:0] p0_readdata, p1_readdata;
    logic              p0_readdatavalid, p1_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic [BE_W-1:0]   m_byteenable_n;
    logic              m_chipselect, m_read_n, m_write_n;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic              m_waitrequest;
    logic              err_orphan;

    sdram_port_arbiter #(.MAX_PEND(8), .STARVE_LIMIT(8)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
        .p0_writedata(p0_writedata), .p0_byteenable(p0_byteenable),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid),
        .m_address(m_address), .m_byteenable_n(m_byteenable_n),
        .m_chipselect(m_chipselect), .m_writedata(m_writedata),
        .m_read_n(m_read_n), .m_write_n(m_write_n), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
        .err_orphan(err_orphan)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // controller memory contents: address 0x000123 reads back as 0xBEEF
    function automatic logic [15:0] data_of(input logic [23:0] a);
        return a[15:0] ^ 16'hBFCC;
    endfunction

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    ret_t        pend_q[$];
    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    int          cyc = 0, acc0 = 0, acc1 = 0, run0 = 0;
    int          rdv_cnt0 = 0, rdv_cnt1 = 0;
    logic [15:0] last_rdata0 = '0;
    logic [15:0] e0, e1;
    logic        starve_chk = 1'b0;
    logic        hold_returns = 1'b0;
    int          release_req = 0, release_done = 0;
    int          orphan_req = 0, orphan_done = 0;

    // stimulus side of the scoreboard: record accepted requests at the clock edge
    always @(posedge clk_clk) begin
        cyc++;
        if (!reset_reset_n) begin
            pend_q.delete();
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            if (m_chipselect && !m_read_n && !m_waitrequest)
                pend_q.push_back('{due: cyc + 3, data: data_of(m_address)});
            if (!p0_waitrequest) begin
                acc0++;
                run0 = starve_chk ? run0 + 1 : 0;
                if (p0_read && !p0_write) exp0_q.push_back(data_of(p0_address));
            end
            if (!p1_waitrequest) begin
                acc1++;
                if (starve_chk) check("starve_run_len", run0, 8);
                run0 = 0;
                if (p1_read && !p1_write) exp1_q.push_back(data_of(p1_address));
            end
        end
    end

    // controller return path, in order, one word per cycle
    always @(negedge clk_clk) begin
        m_readdatavalid = 1'b0;
        m_readdata      = 16'h0000;
        if (!reset_reset_n) begin
            m_readdatavalid = 1'b0;
        end else if (orphan_req != orphan_done) begin
            orphan_done++;
            m_readdatavalid = 1'b1;
            m_readdata      = 16'hDEAD;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
                     (!hold_returns || release_req != release_done)) begin
            if (hold_returns) release_done++;
            m_readdatavalid = 1'b1;
            m_readdata      = pend_q[0].data;
            void'(pend_q.pop_front());
        end
    end

    // checking side of the scoreboard
    always @(negedge clk_clk) begin
        if (p0_readdatavalid) begin
            rdv_cnt0++;
            last_rdata0 = p0_readdata;
            if (exp0_q.size() == 0) begin
                check("p0_unexpected_rdv", 1, 0);
            end else begin
                e0 = exp0_q.pop_front();
                check("p0_readdata", p0_readdata, e0);
                $display("ret port0 data=%h exp=%h", p0_readdata, e0);
            end
        end
        if (p1_readdatavalid) begin
            rdv_cnt1++;
            if (exp1_q.size() == 0) begin
                check("p1_unexpected_rdv", 1, 0);
            end else begin
                e1 = exp1_q.pop_front();
                check("p1_readdata", p1_readdata, e1);
                $display("ret port1 data=%h exp=%h", p1_readdata, e1);
            end
        end
    end

    task automatic chk_reset_state(input string t);
        check({t, "_m_chipselect"}, m_chipselect, 0);
        check({t, "_m_read_n"}, m_read_n, 1);
        check({t, "_m_write_n"}, m_write_n, 1);
        check({t, "_m_byteenable_n"}, m_byteenable_n, 2'b11);
        check({t, "_m_address"}, m_address, 0);
        check({t, "_m_writedata"}, m_writedata, 0);
        check({t, "_p0_waitreq"}, p0_waitrequest, 1);
        check({t, "_p1_waitreq"}, p1_waitrequest, 1);
        check({t, "_p0_rdv"}, p0_readdatavalid, 0);
        check({t, "_p1_rdv"}, p1_readdatavalid, 0);
        check({t, "_p0_readdata"}, p0_readdata, 0);
        check({t, "_p1_readdata"}, p1_readdata, 0);
        check({t, "_err_orphan"}, err_orphan, 0);
        check({t, "_fifo_count"}, 32'(dut.fifo_count), 0);
    endtask

    task automatic single_read(input string nm);
        int c0, c1, lo;
        @(negedge clk_clk);
        p0_address = 24'h000123;
        p0_read    = 1'b1;
        #1 check({nm, "_p0_waitreq"}, p0_waitrequest, 0);
        @(negedge clk_clk);
        p0_read = 1'b0;
        c0 = rdv_cnt0;
        c1 = rdv_cnt1;
        lo = 0;
        check({nm, "_m_read_n"}, m_read_n, 0);
        check({nm, "_m_address"}, m_address, 24'h000123);
        check({nm, "_m_byteenable_n"}, m_byteenable_n, 2'b00);
        repeat (10) begin
            @(negedge clk_clk);
            if (!m_read_n) lo++;
        end
        check({nm, "_extra_read_cycles"}, lo, 0);
        check({nm, "_p0_pulses"}, rdv_cnt0 - c0, 1);
        check({nm, "_p1_pulses"}, rdv_cnt1 - c1, 0);
        check({nm, "_p0_readdata"}, last_rdata0, 16'hBEEF);
        $display("txn %s read 0x000123 done", nm);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (exp0_q.size() == 0 && exp1_q.size() == 0 && pend_q.size() == 0) break;
            @(negedge clk_clk);
        end
        check({nm, "_outstanding"}, exp0_q.size() + exp1_q.size() + pend_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, n;
        reset_reset_n = 1'b0;
        p0_address = '0; p0_read = 1'b1; p0_write = 1'b0; p0_writedata = '0; p0_byteenable = '0;
        p1_address = '0; p1_read = 1'b0; p1_write = 1'b1; p1_writedata = '0; p1_byteenable = '0;
        m_waitrequest = 1'b0;
        repeat (3) @(negedge clk_clk);
        chk_reset_state("rst");
        p0_read  = 1'b0;
        p1_write = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        // single read, data routed to port 0 only
        single_read("t1");

        // write held by controller stall, then the queued read follows
        @(negedge clk_clk);
        m_waitrequest = 1'b1;
        p1_address = 24'h0055AA; p1_writedata = 16'hA5A5; p1_byteenable = 2'b01; p1_write = 1'b1;
        #1 check("ws_p1_waitreq_load", p1_waitrequest, 0);
        @(negedge clk_clk);
        p1_write = 1'b0;
        p0_address = 24'h000777; p0_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("ws_m_write_n", m_write_n, 0);
            check("ws_m_address", m_address, 24'h0055AA);
            check("ws_m_writedata", m_writedata, 16'hA5A5);
            check("ws_m_byteenable_n", m_byteenable_n, 2'b10);
            check("ws_p0_waitreq_stall", p0_waitrequest, 1);
            @(negedge clk_clk);
        end
        m_waitrequest = 1'b0;
        #1 check("ws_p0_waitreq_go", p0_waitrequest, 0);
        @(negedge clk_clk);
        p0_read = 1'b0;
        check("ws_next_m_read_n", m_read_n, 0);
        check("ws_next_m_write_n", m_write_n, 1);
        check("ws_next_m_address", m_address, 24'h000777);
        $display("txn write 0x55AA=0xA5A5 be=01 accepted after stall");
        drain("ws");

        // both ports reading flat out: port 1 every ninth grant
        @(negedge clk_clk);
        a0 = acc0; a1 = acc1; n = 0;
        starve_chk = 1'b1;
        p0_read = 1'b1; p1_read = 1'b1;
        p0_address = 24'($urandom); p1_address = 24'($urandom);
        while ((acc0 - a0) + (acc1 - a1) < 1000 && n < 3000) begin
            @(negedge clk_clk);
            p0_address = 24'($urandom);
            p1_address = 24'($urandom);
            n++;
        end
        starve_chk = 1'b0;
        p0_read = 1'b0; p1_read = 1'b0;
        check("sv_total_reads_reached", ((acc0 - a0) + (acc1 - a1)) >= 1000, 1);
        check("sv_p1_share", ((acc1 - a1) * 9 >= (acc0 - a0) + (acc1 - a1) - 9), 1);
        $display("txn starvation burst p0=%0d p1=%0d", acc0 - a0, acc1 - a1);
        drain("sv");

        // returns withheld: tag FIFO limits outstanding reads to 8
        hold_returns = 1'b1;
        a0 = acc0;
        @(negedge clk_clk);
        p0_read = 1'b1;
        repeat (20) begin
            p0_address = 24'($urandom);
            @(negedge clk_clk);
        end
        #1;
        check("fl_accepted", acc0 - a0, 8);
        check("fl_p0_waitreq_full", p0_waitrequest, 1);
        release_req++;
        repeat (8) begin
            @(negedge clk_clk);
            p0_address = 24'($urandom);
        end
        #1;
        check("fl_accepted_after_return", acc0 - a0, 9);
        check("fl_p0_waitreq_full_again", p0_waitrequest, 1);
        @(negedge clk_clk);
        p0_read = 1'b0;
        hold_returns = 1'b0;
        $display("txn fifo limit reached at %0d reads", acc0 - a0);
        drain("fl");

        // orphan return
        a0 = rdv_cnt0; a1 = rdv_cnt1;
        orphan_req++;
        repeat (4) @(negedge clk_clk);
        check("or_err_set", err_orphan, 1);
        check("or_p0_pulses", rdv_cnt0 - a0, 0);
        check("or_p1_pulses", rdv_cnt1 - a1, 0);
        repeat (10) @(negedge clk_clk);
        check("or_err_sticky", err_orphan, 1);
        #2 reset_reset_n = 1'b0;
        #1 check("or_err_cleared", err_orphan, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        $display("txn orphan return flagged and cleared");

        // async reset with reads outstanding
        hold_returns = 1'b1;
        a0 = acc0;
        @(negedge clk_clk);
        p0_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p0_address = 24'h100 + 24'(i);
            @(negedge clk_clk);
            if (acc0 - a0 >= 4) break;
        end
        p0_read = 1'b0;
        check("mr_reads_pending", acc0 - a0, 4);
        #2 reset_reset_n = 1'b0;
        #1 chk_reset_state("mr");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        hold_returns = 1'b0;
        single_read("mr_after");
        drain("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester arbiter in front of the SDRAM controller's Avalon-MM slave: 24-bit word address, 16-bit data, active-low byteenable/read/write, pipelined reads with readdatavalid.
- Port 0 is the display/refresh reader and has priority. Port 1 is the host/loader read-write port.
- Starvation of port 1 is bounded.
- Read data is returned in order to the port that issued the read, using a port-ID tag FIFO.

Parameters:
- ADDR_W, 24, word address width on all ports.
- DATA_W, 16, data width; byteenable width is DATA_W/8.
- MAX_PEND, 8, maximum outstanding reads (tag FIFO depth); power of two, ≥2.
- STARVE_LIMIT, 8, consecutive port-0 grants allowed while port 1 waits.

Ports:
- clk_clk  in  1  single clock for all logic.
- reset_reset_n  in  1  asynchronous, active-low reset.
- pN_address  in  ADDR_W  (N=0,1) request address.
- pN_read / pN_write  in  1  active-high request strobes.
- pN_writedata  in  DATA_W  write data.
- pN_byteenable  in  DATA_W/8  active-high byte enables.
- pN_waitrequest  out  1  high = request not taken this cycle.
- pN_readdata  out  DATA_W  returned read data.
- pN_readdatavalid  out  1  one-cycle pulse per returned word.
- m_address  out  ADDR_W  to controller address input.
- m_byteenable_n  out  DATA_W/8  to controller.
- m_chipselect  out  1  to controller.
- m_writedata  out  DATA_W  to controller.
- m_read_n  out  1  to controller.
- m_write_n  out  1  to controller.
- m_readdata  in  DATA_W  from controller.
- m_readdatavalid  in  1  from controller.
- m_waitrequest  in  1  from controller.
- err_orphan  out  1  sticky: readdatavalid arrived with tag FIFO empty.

Behaviour:
- Reset values:
  - m_chipselect=0, m_read_n=1, m_write_n=1, m_byteenable_n=all 1, m_address=0, m_writedata=0.
  - pN_readdatavalid=0, pN_readdata=0, err_orphan=0.
  - Tag FIFO empty; starve counter 0.
  - pN_waitrequest=1 while reset is asserted.
- Command stage: one registered slot (cmd_valid).
  - The slot loads when cmd_valid=0, or when cmd_valid=1 and m_waitrequest=0 (accept and reload in the same cycle).
  - Sustained throughput is one command per cycle when the controller does not stall.
- Latency: a request seen at edge T with no stall drives m_* from T+1. Its pN_waitrequest is low during the cycle before edge T.
- pN_waitrequest is combinational: it is low only in the cycle the slot loads port N's request.
- Arbitration among eligible ports:
  - A port is eligible when it asserts read or write.
  - A read is eligible only if (FIFO count + held read in slot) < MAX_PEND.
  - Port 0 wins unless starve_cnt==STARVE_LIMIT and port 1 is eligible; then port 1 wins.
  - starve_cnt increments on each port-0 grant while port 1 is eligible.
  - starve_cnt clears on a port-1 grant, or on any cycle port 1 is not requesting.
- Read and write asserted together on one port: treated as a write; the read is ignored.
- Byte enables are inverted on load (m_byteenable_n = ~pN_byteenable). For reads, m_byteenable_n is all 0.
- Tag FIFO:
  - Push the slot's port ID when a read is accepted (cmd_valid, read, !m_waitrequest).
  - Pop on m_readdatavalid. Simultaneous push and pop is legal; count stays unchanged. Push when full cannot occur by construction.
- Return path, registered (1-cycle latency):
  - pN_readdatavalid <= m_readdatavalid && head==N.
  - Both pN_readdata <= m_readdata unconditionally.
- Orphan: m_readdatavalid with FIFO empty sets err_orphan; no pulse on either port; no pop. err_orphan clears only on reset.
- Writes are posted: the write completes on acceptance and pushes no tag.
- Reset mid-operation: the held command is dropped and the FIFO is flushed. The SDRAM controller shares reset_reset_n, so no stale returns are expected.

Decomposition:
- Package sdram_arb_pkg:
  - ADDR_W, DATA_W, BE_W constants.
  - port_id_t (1 bit).
  - cmd_t struct {addr, wdata, be, is_write, id}.
- Sub-module sdram_tag_fifo: synchronous FIFO of port_id_t, depth MAX_PEND, with count, full and empty outputs and async active-low reset.

Test Plan:
- Single port-0 read of 0x000123, m_waitrequest=0 → m_read_n=0 for exactly one cycle at T+1. Controller returns 0xBEEF 3 cycles later → p0_readdatavalid pulses once with p0_readdata=0xBEEF; p1_readdatavalid stays 0.
- Both ports read continuously, STARVE_LIMIT=8 → port 1 is granted exactly once after every 8 port-0 grants. Returns are routed in issue order with no cross-delivery (scoreboard over 1000 reads).
- m_waitrequest held high for 5 cycles with a port-1 write of 0xA5A5, byteenable=2'b01 → m_* stable for all 5 cycles with m_byteenable_n=2'b10. p1_waitrequest stays high until the load cycle; the next command issues the cycle after acceptance.
- Readdatavalid withheld while port 0 issues reads → exactly 8 reads accepted, then p0_waitrequest stays high. One return → one further read accepted.
- Lone m_readdatavalid with no reads pending → err_orphan=1, no port pulse. err_orphan holds until reset_reset_n is pulsed low.
- reset_reset_n asserted asynchronously mid-burst with 4 reads pending → all outputs at their reset values immediately and FIFO count=0. After release, the first read works normally.
